// File: rtl/normalize_pipe_p.sv
// Two-stage normalize pipeline: classified IEEE-754 operand in, unbiased signed
// exponent and explicit-leading-one mantissa out, optionally even-aligned for sqrt.
module normalize_pipe_p #(
  parameter int EXP_W      = 5,
  parameter int MANT_W     = 10,
  parameter int BIAS       = 2**(EXP_W-1)-1,
  parameter int SQRT_ALIGN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  input  logic              is_normal_in,
  input  logic              is_subnormal_in,
  input  logic              is_nan_in,
  input  logic              is_pinf_in,
  input  logic              is_ninf_in,
  output logic              n_valid,
  input  logic              n_ready,
  output logic              is_num,
  output logic              is_zero,
  output logic              is_nan,
  output logic              is_pinf,
  output logic              is_ninf,
  output logic              sign_out,
  output logic [EXP_W+1:0]  exp_out,
  output logic [MANT_W+1:0] mant_out
);

  localparam int EW = EXP_W + 2;
  localparam int MW = MANT_W + 2;
  localparam int CW = $clog2(MANT_W + 1);
  localparam logic [EW-1:0] BIAS_E = EW'(BIAS);

  function automatic logic [CW-1:0] count_lz(input logic [MANT_W-1:0] m);
    logic [CW-1:0] n;
    logic          found;
    n     = '0;
    found = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (m[i]) found = 1'b1;
        else      n = n + CW'(1);
      end
    end
    return n;
  endfunction

  logic              adv;
  logic              a_valid, a_sign, a_zero;
  logic              a_normal, a_nan, a_pinf, a_ninf;
  logic [EXP_W-1:0]  a_exp;
  logic [MANT_W-1:0] a_mant;
  logic [CW-1:0]     a_clz;

  assign adv     = enable & (~n_valid | n_ready);
  assign s_ready = adv;

  // Stage A: capture operand, detect zero, count leading zeros for subnormals
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid  <= 1'b0;
      a_sign   <= 1'b0;
      a_zero   <= 1'b0;
      a_normal <= 1'b0;
      a_nan    <= 1'b0;
      a_pinf   <= 1'b0;
      a_ninf   <= 1'b0;
      a_exp    <= '0;
      a_mant   <= '0;
      a_clz    <= '0;
    end else if (!enable) begin
      a_valid <= 1'b0;
    end else if (adv) begin
      a_valid  <= s_valid;
      a_sign   <= sign_in;
      a_zero   <= (exp_in == '0) && (mant_in == '0);
      a_normal <= is_normal_in;
      a_nan    <= is_nan_in;
      a_pinf   <= is_pinf_in;
      a_ninf   <= is_ninf_in;
      a_exp    <= exp_in;
      a_mant   <= mant_in;
      a_clz    <= (is_subnormal_in | ~is_normal_in) ? count_lz(mant_in) : '0;
    end
  end

  logic              b_num, b_zero, b_nan, b_pinf, b_ninf;
  logic [EW-1:0]     b_exp;
  logic [MW-1:0]     b_mant;
  logic [MANT_W:0]   sub_sh;

  always_comb begin
    b_num  = 1'b0;
    b_zero = 1'b0;
    b_nan  = 1'b0;
    b_pinf = 1'b0;
    b_ninf = 1'b0;
    b_exp  = '0;
    b_mant = '0;
    sub_sh = '0;
    if (a_nan | a_pinf | a_ninf) begin
      b_nan  = a_nan;
      b_pinf = ~a_nan & a_pinf;
      b_ninf = ~a_nan & ~a_pinf & a_ninf;
      b_exp  = EW'(a_exp);
      b_mant = MW'(a_mant);
    end else if (a_zero) begin
      b_num  = 1'b1;
      b_zero = 1'b1;
    end else if (a_normal) begin
      b_num  = 1'b1;
      b_exp  = EW'(a_exp) - BIAS_E;
      b_mant = {2'b01, a_mant};
    end else begin
      // shift past the leading one so it lands on bit MANT_W
      b_num  = 1'b1;
      b_exp  = '0 - BIAS_E - EW'(a_clz);
      sub_sh = ({1'b0, a_mant} << a_clz) << 1;
      b_mant = {1'b0, sub_sh};
    end
    if ((SQRT_ALIGN != 0) && b_num && !b_zero && b_exp[0]) begin
      b_mant = b_mant << 1;
      b_exp  = b_exp - EW'(1);
    end
  end

  // Stage B: registered outputs, frozen while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      n_valid  <= 1'b0;
      is_num   <= 1'b0;
      is_zero  <= 1'b0;
      is_nan   <= 1'b0;
      is_pinf  <= 1'b0;
      is_ninf  <= 1'b0;
      sign_out <= 1'b0;
      exp_out  <= '0;
      mant_out <= '0;
    end else if (!enable) begin
      n_valid <= 1'b0;
    end else if (adv) begin
      n_valid  <= a_valid;
      is_num   <= b_num;
      is_zero  <= b_zero;
      is_nan   <= b_nan;
      is_pinf  <= b_pinf;
      is_ninf  <= b_ninf;
      sign_out <= a_sign;
      exp_out  <= b_exp;
      mant_out <= b_mant;
    end
  end

endmodule

// File: tb/tb_normalize_pipe_p.sv
// Scoreboard bench for normalize_pipe_p on half precision; one instance with
// sqrt alignment and one without, both fed the same stream.
module tb_normalize_pipe_p;

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, n_ready;
  logic        sign_in;
  logic [4:0]  exp_in;
  logic [9:0]  mant_in;
  logic        is_normal_in, is_subnormal_in, is_nan_in, is_pinf_in, is_ninf_in;

  logic        s_ready, n_valid, is_num, is_zero, is_nan, is_pinf, is_ninf, sign_out;
  logic [6:0]  exp_out;
  logic [11:0] mant_out;

  logic        s_ready0, n_valid0, is_num0, is_zero0, is_nan0, is_pinf0, is_ninf0, sign_out0;
  logic [6:0]  exp_out0;
  logic [11:0] mant_out0;

  normalize_pipe_p #(.SQRT_ALIGN(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .is_normal_in(is_normal_in), .is_subnormal_in(is_subnormal_in), .is_nan_in(is_nan_in),
    .is_pinf_in(is_pinf_in), .is_ninf_in(is_ninf_in),
    .n_valid(n_valid), .n_ready(n_ready),
    .is_num(is_num), .is_zero(is_zero), .is_nan(is_nan), .is_pinf(is_pinf), .is_ninf(is_ninf),
    .sign_out(sign_out), .exp_out(exp_out), .mant_out(mant_out)
  );

  normalize_pipe_p #(.SQRT_ALIGN(0)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .s_valid(s_valid), .s_ready(s_ready0),
    .sign_in(sign_in), .exp_in(exp_in), .mant_in(mant_in),
    .is_normal_in(is_normal_in), .is_subnormal_in(is_subnormal_in), .is_nan_in(is_nan_in),
    .is_pinf_in(is_pinf_in), .is_ninf_in(is_ninf_in),
    .n_valid(n_valid0), .n_ready(n_ready),
    .is_num(is_num0), .is_zero(is_zero0), .is_nan(is_nan0), .is_pinf(is_pinf0), .is_ninf(is_ninf0),
    .sign_out(sign_out0), .exp_out(exp_out0), .mant_out(mant_out0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        sign, num, zero, nan, pinf, ninf;
    logic [6:0]  e1, e0;
    logic [11:0] m1, m0;
    bit          lat;
    int          acc;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rnd_rdy = 1'b0;

  logic [25:0] cur_snap;
  assign cur_snap = {n_valid, sign_out, is_num, is_zero, is_nan, is_pinf, is_ninf, exp_out, mant_out};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Value-level reference: normalise by doubling until the hidden one appears.
  function automatic ent_t model(input logic [15:0] h);
    ent_t r;
    int   e, m, ee, mm;
    e = int'(h[14:10]);
    m = int'(h[9:0]);
    r = '{default: '0};
    r.sign = h[15];
    if (e == 31) begin
      r.nan  = (m != 0);
      r.pinf = (m == 0) && !h[15];
      r.ninf = (m == 0) && h[15];
      r.e1 = 7'(e); r.e0 = 7'(e);
      r.m1 = 12'(m); r.m0 = 12'(m);
    end else if (e == 0 && m == 0) begin
      r.num  = 1'b1;
      r.zero = 1'b1;
    end else begin
      r.num = 1'b1;
      if (e != 0) begin mm = 1024 + m; ee = e - 15; end
      else        begin mm = m;        ee = -14;    end
      while (mm < 1024) begin mm = mm * 2; ee = ee - 1; end
      r.e0 = 7'(ee); r.m0 = 12'(mm);
      if (ee % 2 != 0) begin mm = mm * 2; ee = ee - 1; end
      r.e1 = 7'(ee); r.m1 = 12'(mm);
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_h();
    logic [15:0] h;
    h = 16'($urandom);
    case ($urandom_range(0, 5))
      0: h[14:10] = 5'($urandom_range(1, 30));
      1: begin h[14:10] = 5'd0; h[9:0] = 10'($urandom_range(1, 1023)); end
      2: begin h[14:10] = 5'd0; h[9:0] = 10'd0; end
      3: begin h[14:10] = 5'd31; h[9:0] = 10'd0; end
      4: begin h[14:10] = 5'd31; h[9:0] = 10'($urandom_range(1, 1023)); end
      default: ;
    endcase
    return h;
  endfunction

  task automatic send(input logic [15:0] h, input bit lat, input bit ovr,
                      input logic [6:0] e1, input logic [11:0] m1,
                      input logic [6:0] e0, input logic [11:0] m0);
    ent_t e;
    bit   ok;
    e = model(h);
    if (ovr) begin e.e1 = e1; e.m1 = m1; e.e0 = e0; e.m0 = m0; end
    e.lat = lat;
    sign_in         = h[15];
    exp_in          = h[14:10];
    mant_in         = h[9:0];
    is_normal_in    = (h[14:10] != 5'd0) && (h[14:10] != 5'd31);
    is_subnormal_in = (h[14:10] == 5'd0) && (h[9:0] != 10'd0);
    is_nan_in       = (h[14:10] == 5'd31) && (h[9:0] != 10'd0);
    is_pinf_in      = (h[14:10] == 5'd31) && (h[9:0] == 10'd0) && !h[15];
    is_ninf_in      = (h[14:10] == 5'd31) && (h[9:0] == 10'd0) && h[15];
    s_valid         = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_ready) begin
        e.acc = cyc;
        q.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: beat %h never accepted", h);
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic send_r(input logic [15:0] h);
    send(h, 1'b0, 1'b0, 7'd0, 12'd0, 7'd0, 12'd0);
  endtask

  task automatic drain();
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    n_ready = 1'b1;
    for (int k = 0; k < 300 && q.size() != 0; k++) @(posedge clk);
    if (q.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d beats still pending", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per delivered beat and checks stall hold.
  logic [25:0] prev_snap;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    ent_t e;
    if (prev_stall) chk("stall_hold", 32'(cur_snap), 32'(prev_snap));
    prev_stall = n_valid && !n_ready && enable && !rst;
    prev_snap  = cur_snap;
    if (n_valid && n_ready) begin
      chk("valid_noalign", n_valid0, 1);
      chk("s_ready_noalign", s_ready0, s_ready);
      if (q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_beat: got exp %h mant %h with nothing expected", exp_out, mant_out);
      end else begin
        e = q.pop_front();
        chk("flags", {sign_out, is_num, is_zero, is_nan, is_pinf, is_ninf},
                     {e.sign, e.num, e.zero, e.nan, e.pinf, e.ninf});
        chk("exp_align", exp_out, e.e1);
        chk("mant_align", mant_out, e.m1);
        chk("flags_noalign", {sign_out0, is_num0, is_zero0, is_nan0, is_pinf0, is_ninf0},
                             {e.sign, e.num, e.zero, e.nan, e.pinf, e.ninf});
        chk("exp_noalign", exp_out0, e.e0);
        chk("mant_noalign", mant_out0, e.m0);
        if (e.lat) chk("latency", 32'(cyc - e.acc), 2);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [25:0] snap;
    bit          got;
    rst = 1'b1; enable = 1'b1; s_valid = 1'b0; n_ready = 1'b0;
    sign_in = 1'b0; exp_in = '0; mant_in = '0;
    is_normal_in = 1'b0; is_subnormal_in = 1'b0; is_nan_in = 1'b0;
    is_pinf_in = 1'b0; is_ninf_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(cur_snap), 0);
    chk("reset_noalign", {n_valid0, exp_out0, mant_out0}, 0);
    rst = 1'b0;
    n_ready = 1'b1;
    @(negedge clk);
    chk("s_ready_after_reset", s_ready, 1);
    @(posedge clk); #1;

    // directed values, back-to-back with no stall
    send(16'h3C00, 1, 1, 7'h00, 12'h400, 7'h00, 12'h400);
    send(16'h4000, 1, 1, 7'h00, 12'h800, 7'h01, 12'h400);
    send(16'h0001, 1, 1, 7'h68, 12'h400, 7'h68, 12'h400);
    send(16'h0200, 1, 1, 7'h70, 12'h800, 7'h71, 12'h400);
    send(16'h7E00, 1, 1, 7'h1F, 12'h200, 7'h1F, 12'h200);
    send(16'h8000, 1, 1, 7'h00, 12'h000, 7'h00, 12'h000);
    send(16'h7BFF, 1, 1, 7'h0E, 12'hFFE, 7'h0F, 12'h7FF);
    send(16'h0400, 1, 1, 7'h72, 12'h400, 7'h72, 12'h400);
    send(16'h03FF, 1, 1, 7'h70, 12'hFFC, 7'h71, 12'h7FE);
    send(16'hFC00, 1, 1, 7'h1F, 12'h000, 7'h1F, 12'h000);
    drain();

    // four beats with downstream held off for three cycles
    n_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_r(rand_h());
      end
      begin
        got = 1'b0;
        for (int k = 0; k < 50; k++) begin
          @(negedge clk);
          if (n_valid) begin got = 1'b1; break; end
        end
        chk("stall_first_valid", got, 1);
        snap = cur_snap;
        for (int j = 0; j < 3; j++) begin
          chk("stall_s_ready", s_ready, 0);
          chk("stall_outputs", 32'(cur_snap), 32'(snap));
          if (j < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        n_ready = 1'b1;
      end
    join
    drain();

    // reset with two beats in flight
    n_ready = 1'b0;
    send_r(16'h3C00);
    send_r(16'h4400);
    rst = 1'b1;
    @(negedge clk);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    n_ready = 1'b1;
    chk("midreset_outputs", 32'(cur_snap), 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("midreset_no_stale", n_valid, 0);
    end
    @(posedge clk); #1;

    // flush through enable=0 with beats in flight
    n_ready = 1'b0;
    send_r(16'h4200);
    send_r(16'h0010);
    enable = 1'b0;
    @(negedge clk);
    chk("disable_s_ready", s_ready, 0);
    q.delete();
    snap = cur_snap;
    @(posedge clk); #1;
    chk("disable_n_valid", n_valid, 0);
    chk("disable_data_hold", 32'(cur_snap[24:0]), 32'(snap[24:0]));
    enable = 1'b1;
    n_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("disable_no_stale", n_valid, 0);
    end
    @(posedge clk); #1;

    // randomized stream with random gaps and random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_r(rand_h());
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      if (rnd_rdy) n_ready = ($urandom_range(0, 3) != 0);
    end
  end

endmodule

// File: doc/normalize_pipe_p.md
Name: normalize_pipe_p

Overview:
- Parametrised successor to the half-precision normalize stage of the sqrt datapath.
- Converts a classified IEEE-754 operand into an unbiased signed exponent and an explicit-leading-one mantissa. Subnormals are fully normalised.
- Optionally aligns the exponent to even for the square-root core.
- Two-stage pipeline with valid/ready backpressure. Sits between the classify stage and the sqrt iteration core.

Parameters:
- EXP_W, 5, exponent field width (≥3).
- MANT_W, 10, fraction field width (≥2).
- BIAS, 2^(EXP_W-1)-1 (15), exponent bias.
- SQRT_ALIGN, 1, 1 = force an even exponent for finite non-zero numbers; 0 = plain normalize.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  0 = flush: clears all valids on the next edge and forces s_ready=0.
- s_valid  in  1  input beat valid.
- s_ready  out  1  stage can accept a beat.
- sign_in  in  1  operand sign.
- exp_in  in  EXP_W  biased exponent field.
- mant_in  in  MANT_W  fraction field.
- is_normal_in, is_subnormal_in, is_nan_in, is_pinf_in, is_ninf_in  in  1 each  classification flags from upstream.
- n_valid  out  1  output beat valid.
- n_ready  in  1  downstream accepts the beat.
- is_num, is_zero, is_nan, is_pinf, is_ninf  out  1 each  registered class.
- sign_out  out  1  registered sign.
- exp_out  out  EXP_W+2  signed unbiased exponent.
- mant_out  out  MANT_W+2  mantissa, binary point between bit MANT_W and bit MANT_W-1.

Behaviour:
- Reset (synchronous, rst=1 at an edge): stage A/B valids=0; n_valid=0. All data and flag outputs are 0.
- Pipeline advance: adv = enable & (~n_valid | n_ready).
  - s_ready = adv.
  - A beat transfers when s_valid & s_ready.
  - On adv, stage A captures the input (valid_A <= s_valid) and stage B captures stage A.
  - Bubbles are not collapsed.
- enable=0: valid_A and n_valid are cleared at the next edge. Data registers hold their values.
- Latency: exactly 2 cycles from accept to n_valid with no stall. Throughput is 1 beat per cycle.
- Stall (n_valid & ~n_ready): every output holds its value and no stage updates. Ordering and data are preserved with no loss or duplication.
- Stage A:
  - Registers sign, exp, mant and the flags.
  - Computes zero = (exp_in==0 & mant_in==0).
  - Computes clz = leading zeros of mant_in, in the range 0..MANT_W.
- Stage B, priority order (first matching case wins):
  1. Special (nan | pinf | ninf):
     - is_num=0.
     - exp_out = zero-extended exp_in; mant_out = zero-extended mant_in.
     - Flag priority nan > pinf > ninf; exactly one output flag is set.
  2. zero: is_zero=1, is_num=1, exp_out=0, mant_out=0.
  3. is_normal_in: exp_out = exp_in - BIAS; mant_out = {0, 1, mant_in}.
  4. Otherwise (subnormal):
     - exp_out = -BIAS - clz.
     - mant_out = {0, (mant_in << (clz+1)) truncated to MANT_W+1 bits}.
- SQRT_ALIGN=1: for is_num & ~is_zero with exp_out[0]=1, mant_out <<= 1 (bit MANT_W+1 becomes set) and exp_out -= 1. Special and zero outputs are unaffected.
- Result ranges:
  - exp_out always fits EXP_W+2 bits signed, two's complement.
  - mant_out[MANT_W+1]=0 whenever SQRT_ALIGN=0.
- sign_out = sign_in in all cases, including NaN and zero.
- Reset asserted mid-operation: in-flight beats are discarded. On the first edge with rst=0, s_ready=enable.

Test Plan:
- Accept 0x3C00 (e=15, m=0, normal), n_ready=1 -> 2 cycles later n_valid=1, exp_out=0, mant_out=0x400, is_num=1.
- 0x4000 (e=16, normal), SQRT_ALIGN=1 -> exp_out=0, mant_out=0x800. With SQRT_ALIGN=0 -> exp_out=1, mant_out=0x400.
- Subnormal m=0x001 -> exp_out=-24 (7'h68), mant_out=0x400. Subnormal m=0x200 -> exp_out=-16, mant_out=0x800 (aligned from -15).
- NaN e=31, m=0x200, is_nan_in=1 -> is_nan=1, is_num=0, exp_out=31, mant_out=0x200. Zero 0x8000 -> is_zero=1, sign_out=1, exp_out=0, mant_out=0.
- Stream 4 beats, hold n_ready=0 for 3 cycles after the first n_valid -> outputs stable, s_ready=0, all 4 results delivered in order after release.
- Assert rst for 1 cycle with 2 beats in flight -> n_valid=0 and outputs 0 at the next edge, no stale beat emitted. Then enable=0 -> s_ready=0 and n_valid cleared.
